// File: rtl/adc_log_pkg.sv
// Shared constants and stage payload type for the ADC-to-ln(mV) pipeline.
package adc_log_pkg;

    localparam int SCALE  = 1000;
    localparam int SHIFT  = 16;
    localparam int MV_MAX = 1000;
    localparam int LN2_Q  = 177;
    localparam int FRAC_W = 8;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SAT  = 1;

    // Payload fields are sized for the widest supported configuration.
    localparam int PAY_CH_W = 8;
    localparam int PAY_W    = 16;

    typedef struct packed {
        logic                valid;
        logic [PAY_CH_W-1:0] ch;
        logic [1:0]          flags;
        logic [PAY_W-1:0]    data;
    } stage_t;

endpackage

// File: rtl/adc_log_pipeline_log2_lzd.sv
// Leading-one detector: returns the integer part p of log2(mv) and the
// FRAC_W bits directly below the leading one as the fractional estimate.
module log2_lzd #(
    parameter int  MV_W   = 16,
    parameter int  FRAC_W = 8,
    localparam int P_W    = (MV_W > 1) ? $clog2(MV_W) : 1
) (
    input  logic [MV_W-1:0]   i_mv,
    output logic [P_W-1:0]    o_p,
    output logic [FRAC_W-1:0] o_f
);

    logic [MV_W+FRAC_W-1:0] w_ext;
    logic [MV_W+FRAC_W-1:0] w_align;

    always_comb begin
        o_p = '0;
        for (int i = 0; i < MV_W; i++) begin
            if (i_mv[i[P_W-1:0]]) o_p = P_W'(i);
        end
    end

    // Move the leading one to the top bit; the FRAC_W bits below it are the
    // fraction, with zeros shifted in when fewer bits exist below the one.
    assign w_ext   = {i_mv, FRAC_W'(0)};
    assign w_align = w_ext << (MV_W - 1 - int'(o_p));
    assign o_f     = FRAC_W'(w_align >> (MV_W - 1));

endmodule

// File: rtl/adc_log_pipeline.sv
// Four-stage ADC code -> millivolt -> log2 -> ln(mV) converter feeding the
// capture FIFO, with whole-pipe stall on FIFO full and a refused-sample counter.
module adc_log_pipeline
    import adc_log_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  N_CH   = 4,
    parameter int  SCALE  = adc_log_pkg::SCALE,
    parameter int  SHIFT  = adc_log_pkg::SHIFT,
    parameter int  MV_W   = 16,
    parameter int  MV_MAX = adc_log_pkg::MV_MAX,
    parameter int  FRAC_W = adc_log_pkg::FRAC_W,
    parameter int  LN2_Q  = adc_log_pkg::LN2_Q,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [CH_W-1:0]   adc_ch,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [15:0]       result_data,
    output logic [CH_W-1:0]   result_ch,
    output logic [1:0]        result_flags,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int PROD_W = DATA_W + $clog2(SCALE) + 1;
    localparam int P_W    = (MV_W > 1) ? $clog2(MV_W) : 1;
    localparam int LOG_W  = P_W + FRAC_W;
    localparam int LNP_W  = PAY_W + FRAC_W;

    function automatic logic [MV_W:0] clamp_mv(input logic [PROD_W-1:0] x);
        if (x > PROD_W'(MV_MAX)) return {1'b1, MV_W'(MV_MAX)};
        return {1'b0, MV_W'(x)};
    endfunction

    function automatic logic [PAY_W-1:0] ln_of(input logic [PAY_W-1:0] lg,
                                               input logic zero);
        logic [LNP_W-1:0] prod;
        prod = LNP_W'(lg) * LNP_W'(LN2_Q);
        if (zero) return '0;
        return PAY_W'(prod >> FRAC_W);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    stage_t r_p1, r_p2, r_p3, r_p4;
    stage_t w_s1, w_s2, w_s3, w_s4;
    logic [CNT_W-1:0]  r_drop;
    logic              w_stall;
    logic              w_en;
    logic [PROD_W-1:0] w_prod;
    logic [MV_W:0]     w_mv_sat;
    logic [P_W-1:0]    w_p;
    logic [FRAC_W-1:0] w_f;
    logic              w_unused;

    assign w_stall  = r_p4.valid & fifo_full;
    assign w_en     = ~w_stall;
    assign in_ready = w_en;

    // S1: scale to millivolts and clamp; empty slots carry an all-zero payload
    assign w_prod   = (PROD_W'(adc_data) * PROD_W'(SCALE)) >> SHIFT;
    assign w_mv_sat = clamp_mv(w_prod);

    always_comb begin
        w_s1 = '0;
        if (valid_in) begin
            w_s1.valid            = 1'b1;
            w_s1.ch               = PAY_CH_W'(adc_ch);
            w_s1.flags[FLAG_SAT]  = w_mv_sat[MV_W];
            w_s1.flags[FLAG_ZERO] = (w_mv_sat[MV_W-1:0] == '0);
            w_s1.data             = PAY_W'(w_mv_sat[MV_W-1:0]);
        end
    end

    // S2: leading-one position and fraction packed as {p, f}
    log2_lzd #(
        .MV_W   (MV_W),
        .FRAC_W (FRAC_W)
    ) u_lzd (
        .i_mv (MV_W'(r_p1.data)),
        .o_p  (w_p),
        .o_f  (w_f)
    );

    always_comb begin
        w_s2      = r_p1;
        w_s2.data = PAY_W'({w_p, w_f});
    end

    // S3: fixed-point log2 in 8.8
    always_comb begin
        w_s3      = r_p2;
        w_s3.data = PAY_W'((LOG_W'(r_p2.data[FRAC_W +: P_W]) << FRAC_W)
                           | LOG_W'(r_p2.data[FRAC_W-1:0]));
    end

    // S4: ln = log2 * ln(2), forced to zero for a zero reading
    always_comb begin
        w_s4      = r_p3;
        w_s4.data = ln_of(r_p3.data, r_p3.flags[FLAG_ZERO]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
            r_p4 <= '0;
        end else if (w_en) begin
            r_p1 <= w_s1;
            r_p2 <= w_s2;
            r_p3 <= w_s3;
            r_p4 <= w_s4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= '0;
        end else if (valid_in && !in_ready) begin
            r_drop <= sat_inc(r_drop);
        end
    end

    assign wr_en        = r_p4.valid & ~fifo_full;
    assign result_data  = r_p4.data;
    assign result_ch    = r_p4.ch[CH_W-1:0];
    assign result_flags = r_p4.flags;
    assign drop_cnt     = r_drop;

    assign w_unused = ^{r_p1.data, r_p2.data, r_p4.ch};

endmodule

// File: tb/tb_adc_log_pipeline.sv
// Scoreboard bench for adc_log_pipeline: default instance plus MV_MAX=500
// and CNT_W=4 instances for clamp and counter-saturation behaviour.
module tb_adc_log_pipeline;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  ch;
        logic [1:0]  fl;
    } exp_t;

    // mv: 0, 512, 999, 1, 3, 0, 100, 250
    localparam logic [15:0] V_ADC [8] = '{16'd0, 16'd33555, 16'd65535, 16'd66,
                                          16'd197, 16'd65, 16'd6554, 16'd16384};
    localparam logic [1:0]  V_CH  [8] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
    localparam logic [15:0] V_RES [8] = '{16'd0, 16'd1593, 16'd1761, 16'd0,
                                          16'd265, 16'd0, 16'd1161, 16'd1407};
    localparam logic [1:0]  V_FL  [8] = '{2'b01, 2'b00, 2'b00, 2'b00,
                                          2'b00, 2'b01, 2'b00, 2'b00};

    // MV_MAX=500 instance: mv 500 (sat), 500 (exact, no sat), 501->500 (sat), 0
    localparam logic [15:0] M_ADC [4] = '{16'd65535, 16'd32768, 16'd32834, 16'd0};
    localparam logic [15:0] M_RES [4] = '{16'd1584, 16'd1584, 16'd1584, 16'd0};
    localparam logic [1:0]  M_FL  [4] = '{2'b10, 2'b00, 2'b10, 2'b01};

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] adc_data;
    logic [1:0]  adc_ch;
    logic        valid_in;
    logic        in_ready;
    logic        fifo_full;
    logic        wr_en;
    logic [15:0] result_data;
    logic [1:0]  result_ch;
    logic [1:0]  result_flags;
    logic [15:0] drop_cnt;

    logic [15:0] m_adc;
    logic [1:0]  m_ch;
    logic        m_valid;
    logic        m_in_ready;
    logic        m_fifo_full;
    logic        m_wr_en;
    logic [15:0] m_res;
    logic [1:0]  m_res_ch;
    logic [1:0]  m_res_fl;
    logic [15:0] m_unused_drop;

    logic [15:0] c_adc;
    logic [1:0]  c_ch;
    logic        c_valid;
    logic        c_in_ready;
    logic        c_fifo_full;
    logic        c_unused_wr;
    logic [15:0] c_unused_data;
    logic [1:0]  c_unused_ch;
    logic [1:0]  c_unused_fl;
    logic [3:0]  c_drop_cnt;

    int   checks = 0;
    int   errors = 0;
    int   m_writes = 0;
    exp_t q[$];
    exp_t mq[$];
    exp_t cur;
    exp_t m_cur;

    always #5 clk = ~clk;

    adc_log_pipeline dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_ch(adc_ch),
        .valid_in(valid_in), .in_ready(in_ready), .fifo_full(fifo_full),
        .wr_en(wr_en), .result_data(result_data), .result_ch(result_ch),
        .result_flags(result_flags), .drop_cnt(drop_cnt)
    );

    adc_log_pipeline #(.MV_MAX(500)) dut_m (
        .clk(clk), .rst(rst), .adc_data(m_adc), .adc_ch(m_ch),
        .valid_in(m_valid), .in_ready(m_in_ready), .fifo_full(m_fifo_full),
        .wr_en(m_wr_en), .result_data(m_res), .result_ch(m_res_ch),
        .result_flags(m_res_fl), .drop_cnt(m_unused_drop)
    );

    adc_log_pipeline #(.CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .adc_data(c_adc), .adc_ch(c_ch),
        .valid_in(c_valid), .in_ready(c_in_ready), .fifo_full(c_fifo_full),
        .wr_en(c_unused_wr), .result_data(c_unused_data), .result_ch(c_unused_ch),
        .result_flags(c_unused_fl), .drop_cnt(c_drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected responses are queued at the accepting edge.
    always @(posedge clk) begin
        if (!rst && valid_in && in_ready) q.push_back(cur);
        if (!rst && m_valid && m_in_ready) mq.push_back(m_cur);
    end

    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write data=%0d ch=%0d flags=%0d",
                         result_data, result_ch, result_flags);
            end else begin
                e = q.pop_front();
                if ({result_data, result_ch, result_flags} !== {e.d, e.ch, e.fl}) begin
                    errors++;
                    $display("FAIL result data=%0d ch=%0d flags=%0d expected data=%0d ch=%0d flags=%0d",
                             result_data, result_ch, result_flags, e.d, e.ch, e.fl);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_wr_en) begin
            checks++;
            m_writes++;
            if (mq.size() == 0) begin
                errors++;
                $display("FAIL m_unexpected_write data=%0d flags=%0d", m_res, m_res_fl);
            end else begin
                e = mq.pop_front();
                if ({m_res, m_res_ch, m_res_fl} !== {e.d, e.ch, e.fl}) begin
                    errors++;
                    $display("FAIL m_result data=%0d ch=%0d flags=%0d expected data=%0d ch=%0d flags=%0d",
                             m_res, m_res_ch, m_res_fl, e.d, e.ch, e.fl);
                end
            end
        end
    end

    task automatic drive(input int idx);
        adc_data = V_ADC[idx];
        adc_ch   = V_CH[idx];
        cur      = '{d: V_RES[idx], ch: V_CH[idx], fl: V_FL[idx]};
        valid_in = 1'b1;
    endtask

    task automatic single(input int idx);
        int n;
        drive(idx);
        @(posedge clk);
        #1 valid_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_en && n < 10);
        chk("latency", 32'(n), 32'd4);
        @(posedge clk);
        #1;
    endtask

    task automatic stream8();
        logic acc;
        int   bound;
        for (int idx = 0; idx < 8; idx++) begin
            drive(idx);
            bound = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                bound++;
            end while (!acc && bound < 50);
            if (!acc) chk("stream_accept", 32'(acc), 32'd1);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        adc_data = '0; adc_ch = '0; valid_in = 1'b0; fifo_full = 1'b0; cur = '0;
        m_adc = '0; m_ch = '0; m_valid = 1'b0; m_fifo_full = 1'b0; m_cur = '0;
        c_adc = '0; c_ch = '0; c_valid = 1'b0; c_fifo_full = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_data", 32'(result_data), 32'd0);
        chk("rst_ch", 32'(result_ch), 32'd0);
        chk("rst_flags", 32'(result_flags), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        single(0);
        single(1);
        single(2);

        fork
            stream8();
            begin
                @(posedge clk);
                repeat (3) @(posedge clk);
                #1 fifo_full = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_wr_en", 32'(wr_en), 32'd0);
                    chk("bp_drop", 32'(drop_cnt), 32'(i));
                end
                @(posedge clk);
                #1 fifo_full = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("rel_wr_en", 32'(wr_en), 32'd1);
                end
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("stream_drained", 32'(q.size()), 32'd0);
        chk("stream_drop_total", 32'(drop_cnt), 32'd10);

        drive(3);
        @(posedge clk);
        #1 drive(4);
        @(posedge clk);
        #1 drive(6);
        @(posedge clk);
        #1 valid_in = 1'b0;
        #2 rst = 1'b1;
        q.delete();
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_data", 32'(result_data), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flush_wr_en", 32'(wr_en), 32'd0);
            chk("flush_outputs", 32'({result_data, result_ch, result_flags}), 32'd0);
        end
        @(posedge clk);
        #1;
        single(7);

        for (int i = 0; i < 4; i++) begin
            m_adc   = M_ADC[i];
            m_ch    = 2'(i);
            m_cur   = '{d: M_RES[i], ch: 2'(i), fl: M_FL[i]};
            m_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        m_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("m_drained", 32'(mq.size()), 32'd0);
        chk("m_writes", 32'(m_writes), 32'd4);

        begin
            int n;
            c_fifo_full = 1'b1;
            c_adc       = 16'd100;
            c_valid     = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (c_in_ready && n < 10);
            chk("c_stalled", 32'(c_in_ready), 32'd0);
            chk("c_drop_start", 32'(c_drop_cnt), 32'd0);
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                chk("c_drop", 32'(c_drop_cnt), 32'((i < 15) ? i : 15));
            end
            @(posedge clk);
            #1;
            c_valid     = 1'b0;
            c_fifo_full = 1'b0;
        end

        repeat (4) @(posedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
